cc_pc_update: RTL and testbench

//  Back end of the SEQ execute stage. Latches the ZF/SF/OF flags the execute block produces for OPq,

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/cond_eval.sv | 38 +++
 rtl/cc_pc_update.sv | 163 ++++++++++++++++
 tb/tb_cc_pc_update.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Package     : y86_pkg
// Description : Shared encodings for the SEQ datapath: instruction codes,
//               condition-function codes, status codes and the status FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // Condition-function codes shared by jXX and cmovXX
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Processor status encodings
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Status FSM: RUN until the first fault or halt, then HALT until reset
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational jXX/cmovXX condition evaluation from the
//               condition codes. Unknown function codes evaluate false.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic w_lt;

    assign w_lt = sf ^ of;

    // Decode the condition function against the supplied flags
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = w_lt | zf;
            C_L:     cnd = w_lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~w_lt;
            C_G:     cnd = ~w_lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/cc_pc_update.sv
`default_nettype none
// ============================================================================
// Module      : cc_pc_update
// Description : SEQ execute back end. Latches OPq condition codes, resolves
//               jXX/cmovXX conditions, selects and registers the next PC,
//               tracks retired instructions and owns the status FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_pc_update
    import y86_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      icode,
    input  logic [3:0]      ifun,
    input  logic [XLEN-1:0] valc,
    input  logic [XLEN-1:0] valm,
    input  logic [XLEN-1:0] valp,
    input  logic            zf_in,
    input  logic            sf_in,
    input  logic            of_in,
    input  logic            instr_valid,
    input  logic            imem_error,
    input  logic            dmem_error,
    output logic [XLEN-1:0] pc,
    output logic            cnd,
    output logic            zf,
    output logic            sf,
    output logic            of,
    output logic [2:0]      stat,
    output logic [XLEN-1:0] retired
);

    localparam logic [XLEN-1:0] c_one = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic            r_zf;
    logic            r_sf;
    logic            r_of;
    logic [2:0]      r_stat;
    logic [XLEN-1:0] r_retired;

    logic [2:0]      w_stat_next;
    logic            w_commit;
    logic            w_retire;
    logic            w_cond;
    logic            w_cnd;
    logic [XLEN-1:0] w_next_pc;

    // Conditions always come from the latched flags, never the execute inputs
    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (r_zf),
        .sf   (r_sf),
        .of   (r_of),
        .cnd  (w_cond)
    );

    // Only jXX and cmovXX expose a condition result
    always_comb begin
        w_cnd = 1'b0;
        if ((icode == I_JXX) || (icode == I_CMOV)) begin
            w_cnd = w_cond;
        end
    end

    // Next-PC selection: call and taken jump go to valC, ret to valM
    always_comb begin
        w_next_pc = valp;
        if (icode == I_CALL) begin
            w_next_pc = valc;
        end else if ((icode == I_JXX) && w_cond) begin
            w_next_pc = valc;
        end else if (icode == I_RET) begin
            w_next_pc = valm;
        end
    end

    // Status FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Status FSM next state; fetch address faults outrank illegal
    // instructions, which outrank data faults, which outrank halt
    always_comb begin
        w_state_next = r_state;
        w_stat_next  = r_stat;
        w_commit     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (imem_error) begin
                    w_stat_next  = STAT_ADR;
                    w_state_next = ST_HALT;
                end else if (!instr_valid) begin
                    w_stat_next  = STAT_INS;
                    w_state_next = ST_HALT;
                end else if (dmem_error) begin
                    w_stat_next  = STAT_ADR;
                    w_state_next = ST_HALT;
                end else if (icode == I_HALT) begin
                    w_stat_next  = STAT_HLT;
                    w_state_next = ST_HALT;
                    w_retire     = 1'b1;
                end else begin
                    w_commit = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    // Architectural state: PC, condition codes, status and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_zf      <= 1'b1;
            r_sf      <= 1'b0;
            r_of      <= 1'b0;
            r_stat    <= STAT_AOK;
            r_retired <= '0;
        end else begin
            r_stat <= w_stat_next;
            if (w_commit) begin
                r_pc <= w_next_pc;
                if (icode == I_OPQ) begin
                    r_zf <= zf_in;
                    r_sf <= sf_in;
                    r_of <= of_in;
                end
            end
            if (w_retire) begin
                r_retired <= r_retired + c_one;
            end
        end
    end

    assign pc      = r_pc;
    assign cnd     = w_cnd;
    assign zf      = r_zf;
    assign sf      = r_sf;
    assign of      = r_of;
    assign stat    = r_stat;
    assign retired = r_retired;

endmodule : cc_pc_update
`default_nettype wire

// File: tb/tb_cc_pc_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_pc_update
// Description : Self-checking bench for cc_pc_update: directed vector table,
//               fault sequences, condition sweep and randomized run against
//               an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_pc_update;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      icode = '0;
    logic [3:0]      ifun = '0;
    logic [XLEN-1:0] valc = '0;
    logic [XLEN-1:0] valm = '0;
    logic [XLEN-1:0] valp = '0;
    logic            zf_in = 1'b0;
    logic            sf_in = 1'b0;
    logic            of_in = 1'b0;
    logic            instr_valid = 1'b1;
    logic            imem_error = 1'b0;
    logic            dmem_error = 1'b0;
    logic [XLEN-1:0] pc;
    logic            cnd;
    logic            zf;
    logic            sf;
    logic            of;
    logic [2:0]      stat;
    logic [XLEN-1:0] retired;

    cc_pc_update #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .icode       (icode),
        .ifun        (ifun),
        .valc        (valc),
        .valm        (valm),
        .valp        (valp),
        .zf_in       (zf_in),
        .sf_in       (sf_in),
        .of_in       (of_in),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .pc          (pc),
        .cnd         (cnd),
        .zf          (zf),
        .sf          (sf),
        .of          (of),
        .stat        (stat),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural state of the processor
    logic [63:0] m_pc;
    logic        m_zf, m_sf, m_of;
    logic [2:0]  m_stat;
    logic [63:0] m_retired;
    logic        m_stopped;
    logic        seen_cnd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
        logic less;
        less = (s != o);
        case (f)
            4'd0: return 1'b1;
            4'd1: return less || z;
            4'd2: return less;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !less;
            4'd6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] f);
        if (ic == 4'd2 || ic == 4'd7) return ref_cond(f, m_zf, m_sf, m_of);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = 64'h0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
        m_stat = 3'd1; m_retired = 64'h0; m_stopped = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".flags"}, {61'h0, zf, sf, of}, {61'h0, m_zf, m_sf, m_of});
        chk({tag, ".stat"}, {61'h0, stat}, {61'h0, m_stat});
        chk({tag, ".retired"}, retired, m_retired);
    endtask

    // Reset asserted mid-cycle; outputs must change before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One instruction: drive at posedge+1, check cnd mid-cycle, check state after edge
    task automatic step(input logic [3:0] ic, input logic [3:0] f,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                        input logic zi, input logic si, input logic oi,
                        input logic iv, input logic ie, input logic de);
        logic       c;
        logic [63:0] npc;
        icode = ic; ifun = f; valc = vc; valm = vm; valp = vp;
        zf_in = zi; sf_in = si; of_in = oi;
        instr_valid = iv; imem_error = ie; dmem_error = de;
        #2;
        c = ref_cnd(ic, f);
        seen_cnd = cnd;
        chk("cnd", {63'h0, cnd}, {63'h0, c});
        if (!m_stopped) begin
            if (ie) begin
                m_stat = 3'd3; m_stopped = 1'b1;
            end else if (!iv) begin
                m_stat = 3'd4; m_stopped = 1'b1;
            end else if (de) begin
                m_stat = 3'd3; m_stopped = 1'b1;
            end else if (ic == 4'd0) begin
                m_stat = 3'd2; m_stopped = 1'b1; m_retired = m_retired + 64'd1;
            end else begin
                if (ic == 4'd8) npc = vc;
                else if (ic == 4'd7 && c) npc = vc;
                else if (ic == 4'd9) npc = vm;
                else npc = vp;
                m_pc = npc;
                if (ic == 4'd6) begin
                    m_zf = zi; m_sf = si; m_of = oi;
                end
                m_retired = m_retired + 64'd1;
            end
        end
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] valm;
        logic [63:0] valp;
        logic [2:0]  fin;
        logic [63:0] e_pc;
        logic        e_cnd;
        logic [2:0]  e_flags;
        logic [63:0] e_ret;
    } vec_t;

    vec_t vt[7];

    initial begin
        // Directed program from reset; fin / e_flags are {zf,sf,of}
        vt[0] = '{4'd6, 4'd0, 64'h0,   64'h0,  64'h0A,  3'b010, 64'h0A,  1'b0, 3'b010, 64'd1};
        vt[1] = '{4'd7, 4'd2, 64'h40,  64'h0,  64'h14,  3'b000, 64'h40,  1'b1, 3'b010, 64'd2};
        vt[2] = '{4'd6, 4'd1, 64'h0,   64'h0,  64'h50,  3'b000, 64'h50,  1'b0, 3'b000, 64'd3};
        vt[3] = '{4'd7, 4'd3, 64'h40,  64'h0,  64'h13,  3'b111, 64'h13,  1'b0, 3'b000, 64'd4};
        vt[4] = '{4'd8, 4'd0, 64'h100, 64'h0,  64'h1D,  3'b000, 64'h100, 1'b0, 3'b000, 64'd5};
        vt[5] = '{4'd9, 4'd0, 64'h0,   64'h2C, 64'h101, 3'b000, 64'h2C,  1'b0, 3'b000, 64'd6};
        vt[6] = '{4'd1, 4'd0, 64'h77,  64'h0,  64'h2D,  3'b000, 64'h2D,  1'b0, 3'b000, 64'd7};

        model_reset();
        do_reset();

        for (int i = 0; i < 7; i++) begin
            step(vt[i].icode, vt[i].ifun, vt[i].valc, vt[i].valm, vt[i].valp,
                 vt[i].fin[2], vt[i].fin[1], vt[i].fin[0], 1'b1, 1'b0, 1'b0);
            chk("vec.cnd", {63'h0, seen_cnd}, {63'h0, vt[i].e_cnd});
            chk("vec.pc", pc, vt[i].e_pc);
            chk("vec.flags", {61'h0, zf, sf, of}, {61'h0, vt[i].e_flags});
            chk("vec.retired", retired, vt[i].e_ret);
            chk("vec.stat", {61'h0, stat}, 64'd1);
        end

        // Mid-run asynchronous reset
        do_reset();

        // Illegal instruction: INS, pc frozen, no retire, later edges hold
        step(4'd6, 4'd0, 64'h0, 64'h0, 64'h88, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ins.stat", {61'h0, stat}, 64'd4);
        chk("ins.pc", pc, 64'h0);
        chk("ins.retired", retired, 64'd0);
        step(4'd6, 4'd0, 64'h0, 64'h0, 64'h99, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ins.hold.flags", {61'h0, zf, sf, of}, 64'b100);
        chk("ins.hold.pc", pc, 64'h0);

        // Halt instruction retires and stops
        do_reset();
        step(4'd1, 4'd0, 64'h0, 64'h0, 64'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 4'd0, 64'h0, 64'h0, 64'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hlt.stat", {61'h0, stat}, 64'd2);
        chk("hlt.retired", retired, 64'd2);
        chk("hlt.pc", pc, 64'h5);
        step(4'd8, 4'd0, 64'h300, 64'h0, 64'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hlt.hold.pc", pc, 64'h5);
        chk("hlt.hold.retired", retired, 64'd2);

        // Fetch fault outranks illegal instruction
        do_reset();
        step(4'd1, 4'd0, 64'h0, 64'h0, 64'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("adr.stat", {61'h0, stat}, 64'd3);
        chk("adr.retired", retired, 64'd0);

        // Data fault on an otherwise valid instruction
        do_reset();
        step(4'd5, 4'd0, 64'h0, 64'h0, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("dmem.stat", {61'h0, stat}, 64'd3);
        chk("dmem.pc", pc, 64'h0);
        // cnd keeps evaluating while halted
        step(4'd2, 4'd3, 64'h0, 64'h0, 64'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dmem.cnd", {63'h0, seen_cnd}, 64'd1);

        // Condition sweep: every flag combination, every cmov function code
        do_reset();
        for (int fl = 0; fl < 8; fl++) begin
            step(4'd6, 4'd0, 64'h0, 64'h0, 64'h100 + 64'(fl), fl[2], fl[1], fl[0], 1'b1, 1'b0, 1'b0);
            for (int f = 0; f < 8; f++) begin
                step(4'd2, 4'(f), 64'h0, 64'h0, 64'h200 + 64'(f), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end

        // Randomized program against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ric;
            ric = ($urandom_range(0, 24) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
            step(ric, 4'($urandom_range(0, 7)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 39) != 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 49) == 0));
            if (m_stopped && ($urandom_range(0, 2) == 0)) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_cc_pc_update
`default_nettype wire
